// File: rtl/bcd_score_counter.sv
// bcd_score_counter: multi-digit BCD score accumulator feeding the seven-segment
// digit stage. Points arrive over a valid/ready handshake and are rippled into the
// working score one digit per cycle. The display registers are loaded only once the
// whole add has resolved, so the display never shows a half-carried score.
//
// Build option: define BLANK_LEADING_ZEROS_EN to blank leading zero digits.
// Digit 0 is never blanked. Without the macro, blank_o is tied low.
//
// state  | meaning
// S_IDLE | waiting for an add, add_ready_o high
// S_ADD  | rippling carry through working digit idx_q
// S_SAT  | carry out of the top digit: force all 9s, set overflow
// S_COMMIT | copy working score to display registers
module bcd_score_counter #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic                      clear_i,
   input  logic                      add_valid_i,
   input  logic [3:0]                add_points_i,
   output logic                      add_ready_o,
   output logic [4*NUM_DIGITS-1:0]   bcd_o,
   output logic [NUM_DIGITS-1:0]     blank_o,
   output logic                      overflow_o
);

   localparam int IW = $clog2(NUM_DIGITS + 1);

`ifdef BLANK_LEADING_ZEROS_EN
   localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
`else
   localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SAT, S_COMMIT} state_t;

   state_t                    state_q;
   logic [4*NUM_DIGITS-1:0]   work_q;
   logic [4*NUM_DIGITS-1:0]   bcd_q;
   logic [NUM_DIGITS-1:0]     blank_q;
   logic                      overflow_q;
   logic [IW-1:0]             idx_q;
   // The carry register also holds the initial addend (0-9) for digit 0.
   logic [3:0]                carry_q;

   logic [3:0]                cur_digit;
   logic [4:0]                sum;
   logic [3:0]                digit_d;
   logic                      carry_d;
   logic [3:0]                points_clamped;

`ifdef BLANK_LEADING_ZEROS_EN
   // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
   function automatic logic [NUM_DIGITS-1:0] blank_of(input logic [4*NUM_DIGITS-1:0] d);
      logic upper_zero;
      blank_of   = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero  = upper_zero && (d[4*i +: 4] == 4'd0);
         blank_of[i] = upper_zero;
      end
   endfunction
`endif

   assign points_clamped = (add_points_i > 4'd9) ? 4'd9 : add_points_i;

   // Single-digit BCD adder on the working digit currently selected by idx_q.
   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) cur_digit = work_q[4*i +: 4];
      end
      sum     = {1'b0, cur_digit} + {1'b0, carry_q};
      carry_d = (sum > 5'd9);
      digit_d = carry_d ? 4'(sum - 5'd10) : sum[3:0];
   end

   // Sequencing FSM plus working/display registers; reset and clear share one path.
   always_ff @(posedge clock_i) begin
      if (reset_i || clear_i) begin
         state_q    <= S_IDLE;
         work_q     <= '0;
         bcd_q      <= '0;
         blank_q    <= BLANK_RST;
         overflow_q <= 1'b0;
         idx_q      <= '0;
         carry_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (add_valid_i) begin
                  state_q <= S_ADD;
                  idx_q   <= '0;
                  carry_q <= points_clamped;
               end
            end
            S_ADD: begin
               // Digit 0 is always processed, so a zero-point add still commits.
               if (idx_q != '0 && carry_q == 4'd0) begin
                  state_q <= S_COMMIT;
               end else if (idx_q == IW'(NUM_DIGITS)) begin
                  state_q <= S_SAT;
               end else begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (idx_q == IW'(i)) work_q[4*i +: 4] <= digit_d;
                  end
                  carry_q <= {3'b000, carry_d};
                  idx_q   <= idx_q + 1'b1;
               end
            end
            S_SAT: begin
               work_q     <= {NUM_DIGITS{4'd9}};
               overflow_q <= 1'b1;
               state_q    <= S_COMMIT;
            end
            S_COMMIT: begin
               bcd_q   <= work_q;
`ifdef BLANK_LEADING_ZEROS_EN
               blank_q <= blank_of(work_q);
`else
               blank_q <= '0;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign add_ready_o = (state_q == S_IDLE);
   assign bcd_o       = bcd_q;
   assign blank_o     = blank_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Testbench for bcd_score_counter (NUM_DIGITS=4). Reference model keeps the score
// as a plain integer and derives digits, blanking and latency arithmetically.
module tb_bcd_score_counter;

   localparam int ND   = 4;
   localparam int MAXV = 9999;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic          add_valid = 1'b0;
   logic [3:0]    add_points = '0;
   logic          add_ready;
   logic [4*ND-1:0] bcd;
   logic [ND-1:0] blank;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int score  = 0;
   bit ovf    = 1'b0;

   bcd_score_counter #(.NUM_DIGITS(ND)) dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .clear_i      (clear),
      .add_valid_i  (add_valid),
      .add_points_i (add_points),
      .add_ready_o  (add_ready),
      .bcd_o        (bcd),
      .blank_o      (blank),
      .overflow_o   (overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [4*ND-1:0] to_bcd(input int v);
      logic [4*ND-1:0] r;
      int x;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [ND-1:0] exp_blank(input int v);
      logic [ND-1:0] b;
      int pw;
      b  = '0;
`ifdef BLANK_LEADING_ZEROS_EN
      pw = 10;
      for (int i = 1; i < ND; i++) begin
         b[i] = (v < pw);
         pw   = pw * 10;
      end
`else
      pw = v;
`endif
      return b;
   endfunction

   // Digits visited: digit 0, plus every digit that receives a carry.
   function automatic int digits_k(input int old, input int p);
      int k, m;
      k = 1;
      m = 10;
      for (int i = 1; i < ND; i++) begin
         if ((old % m) + p >= m) k++;
         m = m * 10;
      end
      return k;
   endfunction

   task automatic check_outputs(input string tag);
      checks++;
      if (bcd !== to_bcd(score)) begin
         errors++;
         $display("FAIL %s bcd: got %h expected %h", tag, bcd, to_bcd(score));
      end
      checks++;
      if (blank !== exp_blank(score)) begin
         errors++;
         $display("FAIL %s blank: got %b expected %b", tag, blank, exp_blank(score));
      end
      checks++;
      if (overflow !== ovf) begin
         errors++;
         $display("FAIL %s overflow: got %b expected %b", tag, overflow, ovf);
      end
   endtask

   // One accepted add; junk add_valid while busy must be ignored.
   task automatic do_add(input logic [3:0] pts, input string tag);
      int p, old, newv, k, cycles;
      bit sat, stale;
      p    = (pts > 9) ? 9 : int'(pts);
      old  = score;
      newv = old + p;
      sat  = (newv > MAXV);
      k    = digits_k(old, p);
      checks++;
      if (add_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before: got %b expected 1", tag, add_ready);
      end
      add_valid  = 1'b1;
      add_points = pts;
      @(posedge clock); #1;
      if (sat) begin
         score = MAXV;
         ovf   = 1'b1;
      end else begin
         score = newv;
      end
      cycles = 0;
      stale  = 1'b0;
      while (add_ready !== 1'b1 && cycles < 40) begin
         if (bcd !== to_bcd(old)) stale = 1'b1;
         add_valid  = 1'($urandom_range(0, 1));
         add_points = 4'($urandom_range(0, 15));
         @(posedge clock); #1;
         cycles++;
      end
      add_valid = 1'b0;
      checks++;
      if (cycles >= 40) begin
         errors++;
         $display("FAIL %s timeout: ready still %b after %0d cycles", tag, add_ready, cycles);
      end
      if (!sat) begin
         checks++;
         if (cycles != k + 2) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cycles, k + 2);
         end
      end
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL %s atomic: display changed before commit (got %b expected 0)", tag, stale);
      end
      check_outputs(tag);
   endtask

   task automatic preload(input int target);
      while (score < target) begin
         do_add(4'((target - score > 9) ? 9 : target - score), "preload");
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      score = 0;
      ovf   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      score = 0;
      ovf   = 1'b0;
      check_outputs("reset");
      checks++;
      if (add_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset ready: got %b expected 1", add_ready);
      end
   endtask

   task automatic test_small_adds();
      do_add(4'd7, "add7");
      do_add(4'd5, "add5");
      checks++;
      if (bcd !== 16'h0012) begin
         errors++;
         $display("FAIL small_adds bcd: got %h expected 0012", bcd);
      end
      do_add(4'd0, "add0");
   endtask

   task automatic test_ripple();
      do_clear();
      preload(999);
      do_add(4'd1, "ripple");
      checks++;
      if (bcd !== 16'h1000) begin
         errors++;
         $display("FAIL ripple bcd: got %h expected 1000", bcd);
      end
   endtask

   task automatic test_saturate();
      do_clear();
      preload(9995);
      do_add(4'd9, "sat9");
      do_add(4'd3, "sat3");
      do_add(4'd0, "sat0");
      checks++;
      if (bcd !== 16'h9999 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL saturate: got %h/%b expected 9999/1", bcd, overflow);
      end
   endtask

   // Clear (or reset) landing mid-add, with a concurrent add_valid.
   task automatic test_abort(input bit use_reset, input string tag);
      add_valid  = 1'b1;
      add_points = 4'd3;
      @(posedge clock); #1;
      if (use_reset) reset = 1'b1; else clear = 1'b1;
      add_valid  = 1'b1;
      add_points = 4'd5;
      @(posedge clock); #1;
      reset = 1'b0;
      clear = 1'b0;
      add_valid = 1'b0;
      score = 0;
      ovf   = 1'b0;
      check_outputs(tag);
      checks++;
      if (add_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b expected 1", tag, add_ready);
      end
      repeat (5) @(posedge clock);
      #1;
      check_outputs({tag, "_later"});
   endtask

   task automatic test_clear_priority();
      do_add(4'd4, "pre_clr");
      clear      = 1'b1;
      add_valid  = 1'b1;
      add_points = 4'd6;
      @(posedge clock); #1;
      clear = 1'b0;
      add_valid = 1'b0;
      score = 0;
      checks++;
      if (add_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_prio ready: got %b expected 1", add_ready);
      end
      repeat (6) @(posedge clock);
      #1;
      check_outputs("clr_prio");
   endtask

   task automatic test_clamp();
      do_clear();
      do_add(4'hC, "clampC");
      checks++;
      if (bcd !== 16'h0009) begin
         errors++;
         $display("FAIL clamp bcd: got %h expected 0009", bcd);
      end
      preload(42);
      check_outputs("score42");
   endtask

   task automatic test_random();
      do_clear();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 14) == 0) begin
            do_clear();
            check_outputs("rand_clear");
         end else begin
            do_add(4'($urandom_range(0, 15)), "rand_add");
         end
      end
      preload(9990);
      for (int n = 0; n < 6; n++) do_add(4'($urandom_range(0, 15)), "rand_hi");
   endtask

   initial begin
      test_reset();
      test_small_adds();
      test_ripple();
      test_saturate();
      test_abort(1'b0, "clear_mid");
      do_add(4'd8, "post_clear");
      test_abort(1'b1, "reset_mid");
      test_clear_priority();
      test_clamp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
